// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Shared-bus arbiter for NPROC accumulator processors feeding a circular
//   operand FIFO. One requester at a time is granted. It either FETCHes the
//   FIFO head or SENDs a result back into the FIFO. A reduction is complete
//   (done) when the FIFO holds exactly one word, no fetched operands are
//   outstanding, and the bus is idle.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   -> round-robin arbitration starting after the last grantee
//     undefined -> fixed priority, lowest index wins (default build)
//
// Parameters
//   NPROC  number of processors sharing the bus
//   DEPTH  operand FIFO depth in 32-bit words (power of two)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   req        per-processor bus request
//   gnt        one-hot (or zero) bus grant
//   op         bus opcode: 00 NOP, 01 FETCH, 10 SEND, 11/X/Z NOP
//   signal     one-cycle transfer-complete strobe
//   read       operand returned by a FETCH (held outside XFER)
//   write      result supplied with a SEND
//   load_en    preload strobe (accepted only when idle with no requests)
//   load_data  preload operand
//   count      FIFO occupancy
//   done       registered reduction-complete flag
//   stall      granted FETCH waiting on an empty FIFO
//   ovf        sticky flag: push attempted while FIFO full
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NPROC = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPROC-1:0]         req,
  output logic [NPROC-1:0]         gnt,
  input  logic [1:0]               op,
  output logic                     signal,
  output logic [31:0]              read,
  input  logic [31:0]              write,
  input  logic                     load_en,
  input  logic [31:0]              load_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done,
  output logic                     stall,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (NPROC > 1) ? $clog2(NPROC) : 1;
  // Outstanding operand counter: a few bits of headroom above the FIFO size.
  localparam int OW = AW + 3;

  typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    gidx;        // index of the current grantee
  logic [IW-1:0]    win;         // arbitration winner this cycle
  logic             any_req;
  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    rdp, wrp;
  logic [OW-1:0]    outst;
  logic             full, empty;
  logic             do_grant, do_drop, do_fetch, do_send, do_load;
  logic             push, push_ok;
  logic [31:0]      push_data;

  assign any_req   = |req;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign push      = do_send | do_load;
  assign push_ok   = push & ~full;
  assign push_data = do_send ? write : load_data;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] last_grant;
  logic [IW-1:0] rr_idx;

  // Scan from farthest to nearest so the requester closest after last_grant
  // is the final assignment and therefore wins.
  always_comb begin
    win    = '0;
    rr_idx = '0;
    for (int k = NPROC; k >= 1; k--) begin
      rr_idx = IW'((int'(last_grant) + k) % NPROC);
      if (req[rr_idx]) win = rr_idx;
    end
  end

  // Reset to NPROC-1 so the very first search begins at processor 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              last_grant <= IW'(NPROC - 1);
    else if (state == XFER) last_grant <= gidx;
  end
`else
  // Fixed priority: lowest index is assigned last and wins.
  always_comb begin
    win = '0;
    for (int k = NPROC - 1; k >= 0; k--)
      if (req[k]) win = IW'(k);
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and control strobes
  //   op is compared with ==, so X/Z opcodes fall through as NOP.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    do_grant = 1'b0;
    do_drop  = 1'b0;
    do_fetch = 1'b0;
    do_send  = 1'b0;
    do_load  = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          do_grant = 1'b1;
          state_nx = GRANT;
        end else if (load_en) begin
          do_load = 1'b1;
        end
      end
      GRANT: begin
        // Grantee withdrawing its request aborts with no FIFO change.
        if (!req[gidx]) begin
          do_drop  = 1'b1;
          state_nx = IDLE;
        end else if (op == 2'b01) begin
          if (!empty) begin
            do_fetch = 1'b1;
            state_nx = XFER;
          end else begin
            stall = 1'b1;
          end
        end else if (op == 2'b10) begin
          // A SEND into a full FIFO still completes; only the push is lost.
          do_send  = 1'b1;
          state_nx = XFER;
        end
      end
      XFER:    state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt    <= '0;
      gidx   <= '0;
      signal <= 1'b0;
      read   <= '0;
      count  <= '0;
      rdp    <= '0;
      wrp    <= '0;
      outst  <= '0;
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= (count == (AW+1)'(1)) && (outst == '0) && (state == IDLE) && !any_req;

      if (do_grant) begin
        gnt  <= NPROC'(1) << win;
        gidx <= win;
      end else if (do_drop || state == XFER) begin
        gnt <= '0;
      end

      signal <= do_fetch | do_send;

      if (do_fetch) begin
        read <= mem[rdp];
        rdp  <= rdp + AW'(1);
      end

      if (push_ok)   wrp <= wrp + AW'(1);
      if (push && full) ovf <= 1'b1;

      case ({push_ok, do_fetch})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase

      // Each completed reduction step is two fetches followed by one send.
      if (do_fetch)     outst <= outst + OW'(1);
      else if (do_send) outst <= outst - OW'(2);
    end
  end

  // FIFO storage: no reset, contents are invalid whenever count says so.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wrp] <= push_data;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  localparam int NP = 4;
  localparam int DP = 16;
  localparam int CW = $clog2(DP) + 1;
  localparam logic [1:0] NOP = 2'b00, FETCH = 2'b01, SEND = 2'b10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NP-1:0] req = '0;
  logic [NP-1:0] gnt;
  logic [1:0]    op = NOP;
  logic          signal;
  logic [31:0]   read;
  logic [31:0]   write = '0;
  logic          load_en = 1'b0;
  logic [31:0]   load_data = '0;
  logic [CW-1:0] count;
  logic          done, stall, ovf;

  int checks = 0;
  int fails  = 0;
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  logic        m_ovf = 1'b0;

  bus_arbiter #(.NPROC(NP), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .op(op), .signal(signal),
    .read(read), .write(write), .load_en(load_en), .load_data(load_data),
    .count(count), .done(done), .stall(stall), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; op = NOP; load_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_q.delete(); exp_q.delete(); m_ovf = 1'b0;
  endtask

  // Called at a negedge with the FSM idle and no requests.
  task automatic load(input logic [31:0] v);
    load_en = 1'b1; load_data = v;
    if (model_q.size() < DP) model_q.push_back(v); else m_ovf = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // One full single-requester transaction, starting and ending idle at a negedge.
  task automatic xact(input int p, input logic [1:0] o, input logic [31:0] wd);
    int n;
    logic [NP-1:0] g;
    logic [31:0] e;
    g = NP'(1) << p;
    if (o == FETCH) exp_q.push_back(model_q.pop_front());
    else if (model_q.size() < DP) model_q.push_back(wd);
    else m_ovf = 1'b1;
    req = g; op = o; write = wd;
    @(negedge clk);
    checks++;
    if (gnt !== g) begin fails++; $display("FAIL xact_gnt: got %b expected %b", gnt, g); end
    n = 0;
    while (signal !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (signal !== 1'b1) begin
      fails++; $display("FAIL xact_signal_timeout: got %b expected 1", signal);
    end else if (o == FETCH) begin
      e = exp_q.pop_front();
      checks++;
      if (read !== e) begin fails++; $display("FAIL xact_read: got %h expected %h", read, e); end
    end
    req = '0; op = NOP;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || signal !== 1'b0) begin
      fails++; $display("FAIL xact_gap: got gnt=%b signal=%b expected 0/0", gnt, signal);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    checks++; if (gnt !== '0)     begin fails++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
    checks++; if (signal !== 1'b0) begin fails++; $display("FAIL reset_signal: got %b expected 0", signal); end
    checks++; if (read !== '0)    begin fails++; $display("FAIL reset_read: got %h expected 0", read); end
    checks++; if (count !== '0)   begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if ({done, stall, ovf} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b expected 000", {done, stall, ovf});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fetch_send();
    do_reset();
    load(32'd5); load(32'd7); load(32'd9);
    xact(0, FETCH, 0);
    xact(0, FETCH, 0);
    xact(0, SEND, 32'd12);
    checks++; if (count !== CW'(model_q.size())) begin
      fails++; $display("FAIL fs_count: got %0d expected %0d", count, model_q.size());
    end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL fs_done: got %b expected 0", done); end
    // Drain to confirm the FIFO holds {9,12} in that order.
    xact(0, FETCH, 0);
    xact(0, FETCH, 0);
  endtask

  task automatic test_reduce();
    int          pr [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    logic [1:0]  ops[9] = '{FETCH, FETCH, SEND, FETCH, FETCH, SEND, FETCH, FETCH, SEND};
    logic [31:0] wds[9] = '{0, 0, 3, 0, 0, 7, 0, 0, 10};
    do_reset();
    for (int i = 1; i <= 4; i++) load(32'(i));
    for (int i = 0; i < 9; i++) xact(pr[i], ops[i], wds[i]);
    @(negedge clk); @(negedge clk);
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL reduce_done: got %b expected 1", done); end
    checks++; if (count !== CW'(1)) begin fails++; $display("FAIL reduce_count: got %0d expected 1", count); end
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL reduce_ovf: got %b expected 0", ovf); end
    xact(3, FETCH, 0);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reduce_done_clear: got %b expected 0", done); end
  endtask

  task automatic test_arbitration();
    logic [NP-1:0] eg[4];
    logic [31:0]   e;
    int n;
`ifdef ARB_ROUND_ROBIN_EN
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`else
    eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) load(32'h10 + 32'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(model_q.pop_front());
    req = 4'b1111; op = FETCH;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n = 0;
      while (signal !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (signal !== 1'b1) begin
        fails++; $display("FAIL arb_timeout: got signal=%b expected 1", signal);
      end else begin
        e = exp_q.pop_front();
        if (gnt !== eg[i] || read !== e) begin
          fails++; $display("FAIL arb_grant%0d: got gnt=%b read=%h expected gnt=%b read=%h", i, gnt, read, eg[i], e);
        end
      end
      if (i == 3) begin req = '0; op = NOP; end
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_drop();
    do_reset();
    // load_en coinciding with a request must be ignored.
    req = 4'b0001; load_en = 1'b1; load_data = 32'h99;
    @(negedge clk);
    load_en = 1'b0; req = '0;
    @(negedge clk);
    checks++; if (count !== '0 || ovf !== 1'b0) begin
      fails++; $display("FAIL load_ignored: got count=%0d ovf=%b expected 0/0", count, ovf);
    end
    @(negedge clk);
    load(32'h33);
    req = 4'b0010; op = 2'b11;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin fails++; $display("FAIL drop_gnt: got %b expected 0010", gnt); end
    @(negedge clk);
    checks++; if (signal !== 1'b0) begin fails++; $display("FAIL op11_nop: got signal=%b expected 0", signal); end
    req = '0; op = NOP;
    @(negedge clk);
    checks++; if (gnt !== '0 || count !== CW'(1) || signal !== 1'b0) begin
      fails++; $display("FAIL drop_abort: got gnt=%b count=%0d signal=%b expected 0/1/0", gnt, count, signal);
    end
    xact(1, FETCH, 0);
  endtask

  task automatic test_stall_reset();
    do_reset();
    req = 4'b0001; op = FETCH;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin fails++; $display("FAIL stall_gnt: got %b expected 0001", gnt); end
    @(negedge clk);
    checks++; if (stall !== 1'b1 || gnt !== 4'b0001) begin
      fails++; $display("FAIL stall_hold: got stall=%b gnt=%b expected 1/0001", stall, gnt);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (gnt !== '0 || stall !== 1'b0) begin
      fails++; $display("FAIL stall_reset: got gnt=%b stall=%b expected 0/0", gnt, stall);
    end
    req = '0; op = NOP;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (count !== '0) begin fails++; $display("FAIL stall_count: got %0d expected 0", count); end
  endtask

  task automatic test_ovf_wrap();
    do_reset();
    for (int i = 0; i < DP; i++) load(32'h100 + 32'(i));
    checks++; if (count !== CW'(DP) || ovf !== 1'b0) begin
      fails++; $display("FAIL full_state: got count=%0d ovf=%b expected %0d/0", count, ovf, DP);
    end
    load(32'hDEAD);
    checks++; if (count !== CW'(DP) || ovf !== m_ovf) begin
      fails++; $display("FAIL ovf_set: got count=%0d ovf=%b expected %0d/%b", count, ovf, DP, m_ovf);
    end
    for (int i = 0; i < 20; i++) begin
      xact(0, FETCH, 0);
      load(32'h200 + 32'(i));
    end
    checks++; if (count !== CW'(model_q.size())) begin
      fails++; $display("FAIL wrap_count: got %0d expected %0d", count, model_q.size());
    end
    // Fetch two more to confirm the oldest surviving entries come out in order.
    xact(0, FETCH, 0);
    xact(0, FETCH, 0);
  endtask

  task automatic test_reset_xfer();
    logic [31:0] e;
    int n;
    do_reset();
    load(32'h0000_00AA);
    exp_q.push_back(model_q.pop_front());
    req = 4'b0001; op = FETCH;
    @(negedge clk);
    n = 0;
    while (signal !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    checks++; if (signal !== 1'b1 || read !== e) begin
      fails++; $display("FAIL rx_xfer: got signal=%b read=%h expected 1/%h", signal, read, e);
    end
    reset = 1'b1;
    #1;
    checks++; if (signal !== 1'b0 || gnt !== '0) begin
      fails++; $display("FAIL rx_reset: got signal=%b gnt=%b expected 0/0", signal, gnt);
    end
    req = '0; op = NOP;
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    @(negedge clk);
    checks++; if (count !== '0) begin fails++; $display("FAIL rx_count: got %0d expected 0", count); end
  endtask

  initial begin
    test_reset();
    test_fetch_send();
    test_reduce();
    test_arbitration();
    test_drop();
    test_stall_reset();
    test_ovf_wrap();
    test_reset_xfer();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
